// File: rtl/dht11_axil_slave.sv
// AXI4-Lite register bank for the DHT11 controller (CTRL, STATUS, DATA, SCRATCH); writes ack in 1 cycle, B at +2; reads AR at +1, R at +2.
// B/R are held until bready/rready, and no new AW/W or AR is accepted on a channel while its response is stalled.
module dht11_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            clock,
    input  logic                            reset,

    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [2:0]                      s_axi_awprot,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,

    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [2:0]                      s_axi_arprot,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,

    output logic                            dht_start,
    input  logic                            dht_busy,
    input  logic                            dht_data_valid,
    input  logic [15:0]                     dht_humidity,
    input  logic [15:0]                     dht_temperature,
    input  logic                            dht_checksum_err,
    output logic                            irq
);

    localparam int DW     = C_S_AXI_DATA_WIDTH;
    localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_DATA    = 2'd2;
    localparam logic [1:0] REG_SCRATCH = 2'd3;

    typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} rstate_t;

    wstate_t wstate, wstate_nxt;
    rstate_t rstate, rstate_nxt;

    logic          irq_en;
    logic          done;
    logic          ckerr;
    logic [31:0]   data_reg;
    logic [DW-1:0] scratch;
    logic [DW-1:0] rd_mux;

    logic       wr_en;
    logic       wr_low;
    logic [1:0] wr_sel;
    logic [1:0] rd_sel;

    logic unused_ok;
    assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    // ------------------------------------------------------------------
    // Write channel FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            wstate <= W_IDLE;
        end else begin
            wstate <= wstate_nxt;
        end
    end

    always_comb begin
        wstate_nxt    = wstate;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        case (wstate)
            W_IDLE: begin
                // Both halves must be present before either ready is raised.
                if (s_axi_awvalid && s_axi_wvalid) begin
                    wstate_nxt = W_ACK;
                end
            end
            W_ACK: begin
                s_axi_awready = 1'b1;
                s_axi_wready  = 1'b1;
                wstate_nxt    = W_RESP;
            end
            W_RESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) begin
                    wstate_nxt = W_IDLE;
                end
            end
            default: wstate_nxt = W_IDLE;
        endcase
    end

    assign s_axi_bresp = 2'b00;

    // ------------------------------------------------------------------
    // Read channel FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            rstate <= R_IDLE;
        end else begin
            rstate <= rstate_nxt;
        end
    end

    always_comb begin
        rstate_nxt    = rstate;
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        case (rstate)
            R_IDLE: begin
                if (s_axi_arvalid) begin
                    rstate_nxt = R_ACK;
                end
            end
            R_ACK: begin
                s_axi_arready = 1'b1;
                rstate_nxt    = R_DATA;
            end
            R_DATA: begin
                s_axi_rvalid = 1'b1;
                if (s_axi_rready) begin
                    rstate_nxt = R_IDLE;
                end
            end
            default: rstate_nxt = R_IDLE;
        endcase
    end

    assign s_axi_rresp = 2'b00;

    // ------------------------------------------------------------------
    // Register bank
    // ------------------------------------------------------------------
    assign wr_en  = (wstate == W_ACK);
    assign wr_sel = s_axi_awaddr[3:2];
    assign wr_low = wr_en && s_axi_wstrb[0];

    always_ff @(posedge clock) begin
        if (reset) begin
            irq_en    <= 1'b0;
            done      <= 1'b0;
            ckerr     <= 1'b0;
            data_reg  <= 32'd0;
            dht_start <= 1'b0;
            irq       <= 1'b0;
        end else begin
            if (wr_low && wr_sel == REG_CTRL) begin
                irq_en <= s_axi_wdata[1];
            end

            // Sensor set beats a simultaneous software clear.
            if (dht_data_valid) begin
                done     <= 1'b1;
                data_reg <= {dht_humidity, dht_temperature};
            end else if (wr_low && wr_sel == REG_STATUS && s_axi_wdata[1]) begin
                done <= 1'b0;
            end

            if (dht_data_valid && dht_checksum_err) begin
                ckerr <= 1'b1;
            end else if (wr_low && wr_sel == REG_STATUS && s_axi_wdata[2]) begin
                ckerr <= 1'b0;
            end

            dht_start <= wr_low && (wr_sel == REG_CTRL) && s_axi_wdata[0] && !dht_busy;
            irq       <= irq_en & done;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            scratch <= '0;
        end else begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wr_en && wr_sel == REG_SCRATCH && s_axi_wstrb[b]) begin
                    scratch[8*b +: 8] <= s_axi_wdata[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read data
    // ------------------------------------------------------------------
    assign rd_sel = s_axi_araddr[3:2];

    always_comb begin
        rd_mux = '0;
        case (rd_sel)
            REG_CTRL:    rd_mux = {{(DW-2){1'b0}}, irq_en, 1'b0};
            REG_STATUS:  rd_mux = {{(DW-3){1'b0}}, ckerr, done, dht_busy};
            REG_DATA:    rd_mux = data_reg;
            REG_SCRATCH: rd_mux = scratch;
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s_axi_rdata <= '0;
        end else if (rstate == R_ACK) begin
            s_axi_rdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_dht11_axil_slave.sv
// Randomized bench for dht11_axil_slave: directed register scenarios then random
// writes/reads/sensor samples checked against a register-level model.
module tb_dht11_axil_slave;

    logic        clock;
    logic        reset;
    logic [3:0]  s_axi_awaddr;
    logic [2:0]  s_axi_awprot;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [3:0]  s_axi_araddr;
    logic [2:0]  s_axi_arprot;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic        dht_start;
    logic        dht_busy;
    logic        dht_data_valid;
    logic [15:0] dht_humidity;
    logic [15:0] dht_temperature;
    logic        dht_checksum_err;
    logic        irq;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic        m_irq_en;
    logic        m_done;
    logic        m_ckerr;
    logic [31:0] m_data;
    logic [31:0] m_scratch;

    logic [31:0] got;

    dht11_axil_slave dut (
        .clock            (clock),
        .reset            (reset),
        .s_axi_awaddr     (s_axi_awaddr),
        .s_axi_awprot     (s_axi_awprot),
        .s_axi_awvalid    (s_axi_awvalid),
        .s_axi_awready    (s_axi_awready),
        .s_axi_wdata      (s_axi_wdata),
        .s_axi_wstrb      (s_axi_wstrb),
        .s_axi_wvalid     (s_axi_wvalid),
        .s_axi_wready     (s_axi_wready),
        .s_axi_bresp      (s_axi_bresp),
        .s_axi_bvalid     (s_axi_bvalid),
        .s_axi_bready     (s_axi_bready),
        .s_axi_araddr     (s_axi_araddr),
        .s_axi_arprot     (s_axi_arprot),
        .s_axi_arvalid    (s_axi_arvalid),
        .s_axi_arready    (s_axi_arready),
        .s_axi_rdata      (s_axi_rdata),
        .s_axi_rresp      (s_axi_rresp),
        .s_axi_rvalid     (s_axi_rvalid),
        .s_axi_rready     (s_axi_rready),
        .dht_start        (dht_start),
        .dht_busy         (dht_busy),
        .dht_data_valid   (dht_data_valid),
        .dht_humidity     (dht_humidity),
        .dht_temperature  (dht_temperature),
        .dht_checksum_err (dht_checksum_err),
        .irq              (irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [3:0] a);
        case (a[3:2])
            2'd0:    return {30'd0, m_irq_en, 1'b0};
            2'd1:    return {29'd0, m_ckerr, m_done, dht_busy};
            2'd2:    return m_data;
            default: return m_scratch;
        endcase
    endfunction

    task automatic model_reset();
        m_irq_en  = 1'b0;
        m_done    = 1'b0;
        m_ckerr   = 1'b0;
        m_data    = 32'd0;
        m_scratch = 32'd0;
    endtask

    task automatic model_sensor(input logic [15:0] h, input logic [15:0] t, input logic e);
        m_data = {h, t};
        m_done = 1'b1;
        if (e) m_ckerr = 1'b1;
    endtask

    // lead > 0: AW leads W by lead cycles; lead < 0: W leads AW.
    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int lead, input int bwait, input bit coincide,
                             input logic [15:0] h, input logic [15:0] t, input logic e);
        logic exp_start;
        int   n;
        n = (lead < 0) ? -lead : lead;
        s_axi_awaddr = a;
        s_axi_wdata  = d;
        s_axi_wstrb  = s;
        if (lead >= 0) s_axi_awvalid = 1'b1;
        else           s_axi_wvalid  = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            chk("early_awready", 32'(s_axi_awready), 32'd0);
            chk("early_wready", 32'(s_axi_wready), 32'd0);
        end
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        tick();
        chk("awready", 32'(s_axi_awready), 32'd1);
        chk("wready", 32'(s_axi_wready), 32'd1);
        chk("bvalid_early", 32'(s_axi_bvalid), 32'd0);
        if (coincide) begin
            dht_humidity     = h;
            dht_temperature  = t;
            dht_checksum_err = e;
            dht_data_valid   = 1'b1;
        end
        exp_start = (a[3:2] == 2'd0) && s[0] && d[0] && !dht_busy;
        if (a[3:2] == 2'd0 && s[0]) m_irq_en = d[1];
        if (a[3:2] == 2'd1 && s[0]) begin
            if (d[1]) m_done  = 1'b0;
            if (d[2]) m_ckerr = 1'b0;
        end
        if (a[3:2] == 2'd3) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) m_scratch[8*b +: 8] = d[8*b +: 8];
        end
        if (coincide) model_sensor(h, t, e);
        tick();
        dht_data_valid = 1'b0;
        chk("awready_drop", 32'(s_axi_awready), 32'd0);
        chk("bvalid", 32'(s_axi_bvalid), 32'd1);
        chk("bresp", 32'(s_axi_bresp), 32'd0);
        chk("dht_start", 32'(dht_start), 32'(exp_start));
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        s_axi_awaddr  = 4'($urandom);
        s_axi_wdata   = $urandom;
        for (int i = 0; i < bwait; i++) begin
            tick();
            chk("bvalid_hold", 32'(s_axi_bvalid), 32'd1);
            chk("start_one_cycle", 32'(dht_start), 32'd0);
        end
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
        chk("bvalid_clear", 32'(s_axi_bvalid), 32'd0);
        chk("start_one_cycle", 32'(dht_start), 32'd0);
        chk("irq_after_wr", 32'(irq), 32'(m_irq_en & m_done));
    endtask

    task automatic axi_read(input logic [3:0] a, input int stall, output logic [31:0] val);
        logic [31:0] exp;
        s_axi_araddr  = a;
        s_axi_arvalid = 1'b1;
        tick();
        chk("arready", 32'(s_axi_arready), 32'd1);
        chk("rvalid_early", 32'(s_axi_rvalid), 32'd0);
        exp = model_rd(a);
        tick();
        s_axi_arvalid = 1'b0;
        s_axi_araddr  = 4'($urandom);
        chk("arready_drop", 32'(s_axi_arready), 32'd0);
        chk("rvalid", 32'(s_axi_rvalid), 32'd1);
        chk("rdata", s_axi_rdata, exp);
        chk("rresp", 32'(s_axi_rresp), 32'd0);
        val = s_axi_rdata;
        for (int i = 0; i < stall; i++) begin
            tick();
            chk("rvalid_hold", 32'(s_axi_rvalid), 32'd1);
            chk("rdata_hold", s_axi_rdata, exp);
        end
        s_axi_rready = 1'b1;
        tick();
        s_axi_rready = 1'b0;
        chk("rvalid_clear", 32'(s_axi_rvalid), 32'd0);
    endtask

    task automatic sensor(input logic [15:0] h, input logic [15:0] t, input logic e);
        logic old_irq;
        old_irq          = m_irq_en & m_done;
        dht_humidity     = h;
        dht_temperature  = t;
        dht_checksum_err = e;
        dht_data_valid   = 1'b1;
        model_sensor(h, t, e);
        tick();
        dht_data_valid   = 1'b0;
        dht_humidity     = 16'($urandom);
        dht_temperature  = 16'($urandom);
        dht_checksum_err = 1'($urandom);
        chk("irq_lag", 32'(irq), 32'(old_irq));
        tick();
        chk("irq_follow", 32'(irq), 32'(m_irq_en & m_done));
    endtask

    initial begin
        reset = 1'b1;
        s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
        s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
        dht_busy = 1'b0; dht_data_valid = 1'b0; dht_humidity = '0;
        dht_temperature = '0; dht_checksum_err = 1'b0;
        model_reset();
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_awready", 32'(s_axi_awready), 32'd0);
        chk("rst_wready", 32'(s_axi_wready), 32'd0);
        chk("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
        chk("rst_arready", 32'(s_axi_arready), 32'd0);
        chk("rst_rvalid", 32'(s_axi_rvalid), 32'd0);
        chk("rst_rdata", s_axi_rdata, 32'd0);
        chk("rst_start", 32'(dht_start), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        tick();
        for (int r = 0; r < 4; r++) axi_read(4'(r * 4), 0, got);

        // SCRATCH byte-strobe merge
        axi_write(4'hC, 32'hA5A5_1234, 4'hF, 0, 0, 1'b0, 16'd0, 16'd0, 1'b0);
        axi_write(4'hC, 32'hFFFF_FFFF, 4'b0010, 0, 0, 1'b0, 16'd0, 16'd0, 1'b0);
        axi_read(4'hC, 0, got);
        chk("scratch_merge", got, 32'hA5A5_FF34);

        // AW ahead of W, then W ahead of AW
        axi_write(4'hC, 32'h1111_2222, 4'hF, 3, 1, 1'b0, 16'd0, 16'd0, 1'b0);
        axi_write(4'hC, 32'h3333_4444, 4'hF, -2, 0, 1'b0, 16'd0, 16'd0, 1'b0);
        tick();
        chk("single_bresp", 32'(s_axi_bvalid), 32'd0);

        // START with idle and busy sensor
        dht_busy = 1'b0;
        axi_write(4'h0, 32'h3, 4'hF, 0, 0, 1'b0, 16'd0, 16'd0, 1'b0);
        axi_read(4'h0, 0, got);
        chk("ctrl_readback", got, 32'h2);
        dht_busy = 1'b1;
        axi_write(4'h0, 32'h3, 4'hF, 0, 0, 1'b0, 16'd0, 16'd0, 1'b0);
        axi_read(4'h4, 0, got);
        chk("status_busy", got, 32'h1);
        dht_busy = 1'b0;

        // Sample capture, interrupt, W1C
        sensor(16'h3700, 16'h1905, 1'b1);
        chk("irq_set", 32'(irq), 32'd1);
        axi_read(4'h8, 0, got);
        chk("data_capture", got, 32'h3700_1905);
        axi_read(4'h4, 0, got);
        chk("status_done_ckerr", got, 32'h6);
        axi_write(4'h4, 32'h6, 4'h1, 0, 0, 1'b0, 16'd0, 16'd0, 1'b0);
        chk("irq_cleared", 32'(irq), 32'd0);
        axi_read(4'h4, 0, got);
        chk("status_cleared", got, 32'h0);

        // W1C with strobe byte 0 off has no effect
        sensor(16'h0102, 16'h0304, 1'b0);
        axi_write(4'h4, 32'h6, 4'hE, 0, 0, 1'b0, 16'd0, 16'd0, 1'b0);
        axi_read(4'h4, 0, got);
        chk("status_strb_gate", got, 32'h2);

        // W1C coincident with new sample
        axi_write(4'h4, 32'h2, 4'hF, 0, 0, 1'b1, 16'h4242, 16'h1717, 1'b0);
        axi_read(4'h4, 0, got);
        chk("done_set_wins", got[1], 32'd1);

        // Random traffic
        for (int it = 0; it < 80; it++) begin
            int op;
            op = int'($urandom_range(0, 9));
            if (op < 4) begin
                axi_write(4'($urandom), $urandom, 4'($urandom), int'($urandom_range(0, 6)) - 3,
                          int'($urandom_range(0, 3)), 1'($urandom_range(0, 4) == 0),
                          16'($urandom), 16'($urandom), 1'($urandom));
            end else if (op < 8) begin
                axi_read(4'($urandom), int'($urandom_range(0, 3)), got);
            end else if (op == 8) begin
                sensor(16'($urandom), 16'($urandom), 1'($urandom));
            end else begin
                dht_busy = 1'($urandom);
                tick();
            end
        end

        // Stalled DATA read, then reset during the stall
        dht_busy = 1'b0;
        axi_write(4'h0, 32'h2, 4'h1, 0, 0, 1'b0, 16'd0, 16'd0, 1'b0);
        sensor(16'hBEEF, 16'hCAFE, 1'b0);
        axi_read(4'h8, 5, got);
        chk("stalled_data", got, 32'hBEEF_CAFE);
        s_axi_araddr  = 4'h8;
        s_axi_arvalid = 1'b1;
        tick();
        tick();
        s_axi_arvalid = 1'b0;
        repeat (3) begin
            tick();
            chk("stall_rvalid", 32'(s_axi_rvalid), 32'd1);
        end
        reset = 1'b1;
        tick();
        chk("rst_mid_rvalid", 32'(s_axi_rvalid), 32'd0);
        chk("rst_mid_rdata", s_axi_rdata, 32'd0);
        chk("rst_mid_irq", 32'(irq), 32'd0);
        reset = 1'b0;
        model_reset();
        tick();
        chk("no_r_after_rst", 32'(s_axi_rvalid), 32'd0);
        axi_read(4'hC, 0, got);
        chk("scratch_after_rst", got, 32'd0);

        // Reset during write acknowledge: no B response
        s_axi_awaddr  = 4'hC;
        s_axi_wdata   = 32'hDEAD_BEEF;
        s_axi_wstrb   = 4'hF;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        tick();
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_wr_awready", 32'(s_axi_awready), 32'd0);
        repeat (2) begin
            tick();
            chk("rst_wr_no_b", 32'(s_axi_bvalid), 32'd0);
        end
        axi_read(4'hC, 0, got);
        chk("rst_wr_scratch", got, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
